// File: rtl/wb_commit_stage.sv
// wb_commit_stage
//   Final pipeline stage: decodes the stage-3 opcode, commits register-file
//   writes one cycle after acceptance, and waits for load data.
//   A load that sees no data within TMO cycles is abandoned and flagged.
//   The last committed write is kept in a forward register for bypassing.
//
// Parameters
//   DW       data width
//   AW       register-address width
//   TMO      maximum load-wait cycles (2..255)
//   R0_ZERO  1 = writes to register 0 are dropped
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid, opcode, rd   incoming instruction and destination register
//   rs1_val, alu_val,
//   imm_val                write-data sources for MOVE / ALU / MOVEI
//   mem_rdata, mem_rvalid  load return data and its valid strobe
//   in_ready, stall        stage can accept / cannot accept (state decode)
//   wb_en, wb_addr,
//   wb_data                registered register-file write port
//   fwd_valid, fwd_addr,
//   fwd_data               last committed write
//   illegal_op, mem_err    one-cycle error pulses
//   wb_count               committed-write counter (wraps)
module wb_commit_stage #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int TMO     = 16,
  parameter int R0_ZERO = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [5:0]    opcode,
  input  logic [AW-1:0] rd,
  input  logic [DW-1:0] rs1_val,
  input  logic [DW-1:0] alu_val,
  input  logic [DW-1:0] imm_val,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rvalid,
  output logic          in_ready,
  output logic          stall,
  output logic          wb_en,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_addr,
  output logic [DW-1:0] fwd_data,
  output logic          illegal_op,
  output logic          mem_err,
  output logic [15:0]   wb_count
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t        state, state_nxt;
  logic [7:0]    wait_cnt, wait_cnt_nxt;
  logic [AW-1:0] ld_rd, ld_rd_nxt;

  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_commit;
  logic          illegal_nxt;
  logic          mem_err_nxt;

  assign in_ready = (state == IDLE);
  assign stall    = ~in_ready;

  // State register, wait counter and the latched load destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      ld_rd    <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      ld_rd    <= ld_rd_nxt;
    end
  end

  // Decode and next-state logic. Produces a write request that the output
  // register below commits on the following edge; mem_rvalid only matters
  // while waiting, so a coincident strobe at LOAD acceptance is ignored.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    ld_rd_nxt    = ld_rd;
    wr_req       = 1'b0;
    wr_addr      = rd;
    wr_data      = alu_val;
    illegal_nxt  = 1'b0;
    mem_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          case (opcode)
            6'h00, 6'h03: ;
            6'h01, 6'h02, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h11, 6'h12, 6'h13, 6'h14: begin
              wr_req  = 1'b1;
              wr_data = alu_val;
            end
            6'h04: begin
              ld_rd_nxt    = rd;
              wait_cnt_nxt = '0;
              state_nxt    = WAIT_MEM;
            end
            6'h05: begin
              wr_req  = 1'b1;
              wr_data = rs1_val;
            end
            6'h10: begin
              wr_req  = 1'b1;
              wr_data = imm_val;
            end
            default: illegal_nxt = 1'b1;
          endcase
        end
      end
      WAIT_MEM: begin
        wr_addr = ld_rd;
        wr_data = mem_rdata;
        if (mem_rvalid) begin
          wr_req       = 1'b1;
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == TMO_LAST) begin
          mem_err_nxt  = 1'b1;
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register-0 suppression only drops the write; FSM movement is unaffected.
  assign wr_commit = wr_req && !((R0_ZERO != 0) && (wr_addr == '0));

  // Registered write port, forward register, pulses and commit counter.
  // The write port holds its last value when idle, except that an illegal
  // opcode drives all-ones onto wb_data as a visible marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      fwd_valid  <= 1'b0;
      fwd_addr   <= '0;
      fwd_data   <= '0;
      illegal_op <= 1'b0;
      mem_err    <= 1'b0;
      wb_count   <= '0;
    end else begin
      wb_en      <= wr_commit;
      illegal_op <= illegal_nxt;
      mem_err    <= mem_err_nxt;
      if (wr_commit) begin
        wb_addr   <= wr_addr;
        wb_data   <= wr_data;
        fwd_valid <= 1'b1;
        fwd_addr  <= wr_addr;
        fwd_data  <= wr_data;
        wb_count  <= wb_count + 16'd1;
      end else if (illegal_nxt) begin
        wb_data <= '1;
      end
    end
  end

endmodule

// File: tb/tb_wb_commit_stage.sv
// tb_wb_commit_stage
//   Directed bench for wb_commit_stage built with TMO=4 so load timeouts
//   are short. Inputs change 1 ns after a rising edge; outputs are checked
//   1 ns after the following rising edge.
module tb_wb_commit_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [5:0]  opcode;
  logic [4:0]  rd;
  logic [31:0] rs1_val, alu_val, imm_val, mem_rdata;
  logic        mem_rvalid;
  logic        in_ready, stall, wb_en, fwd_valid, illegal_op, mem_err;
  logic [4:0]  wb_addr, fwd_addr;
  logic [31:0] wb_data, fwd_data;
  logic [15:0] wb_count;

  int errors = 0;
  int checks = 0;

  wb_commit_stage #(.DW(32), .AW(5), .TMO(4), .R0_ZERO(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .rd(rd),
    .rs1_val(rs1_val), .alu_val(alu_val), .imm_val(imm_val),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .in_ready(in_ready), .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .illegal_op(illegal_op), .mem_err(mem_err),
    .wb_count(wb_count)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction slot (in_valid low means bubble).
  task automatic applyStimulus(input logic v, input logic [5:0] op,
                               input logic [4:0] r, input logic [31:0] data);
    in_valid = v;
    opcode   = op;
    rd       = r;
    alu_val  = data;
    rs1_val  = data;
    imm_val  = data;
  endtask

  // One counted comparison.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  initial begin
    rst = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    applyStimulus(1'b0, 6'h00, 5'd0, 32'h0);
    #1;

    // Reset, with in_valid asserted to show reset priority
    applyStimulus(1'b1, 6'h01, 5'd7, 32'h11);
    tick();
    tick();
    checkOutput("rst_wb_en", 32'(wb_en), 32'h0);
    checkOutput("rst_wb_count", 32'(wb_count), 32'h0);
    checkOutput("rst_fwd_valid", 32'(fwd_valid), 32'h0);
    checkOutput("rst_wb_data", wb_data, 32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 6'h00, 5'd0, 32'h0);
    tick();
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'h1);

    // ADD rd=7
    applyStimulus(1'b1, 6'h01, 5'd7, 32'h0000_00AA);
    tick();
    applyStimulus(1'b0, 6'h00, 5'd0, 32'h0);
    checkOutput("add_wb_en", 32'(wb_en), 32'h1);
    checkOutput("add_wb_addr", 32'(wb_addr), 32'h7);
    checkOutput("add_wb_data", wb_data, 32'hAA);
    checkOutput("add_fwd_valid", 32'(fwd_valid), 32'h1);
    checkOutput("add_fwd_addr", 32'(fwd_addr), 32'h7);
    checkOutput("add_fwd_data", fwd_data, 32'hAA);
    checkOutput("add_count", 32'(wb_count), 32'h1);
    tick();
    checkOutput("add_pulse_end", 32'(wb_en), 32'h0);
    checkOutput("add_data_hold", wb_data, 32'hAA);

    // MOVE rd=2, MOVEI rd=4
    applyStimulus(1'b1, 6'h05, 5'd2, 32'h55);
    tick();
    checkOutput("move_wb_data", wb_data, 32'h55);
    checkOutput("move_wb_addr", 32'(wb_addr), 32'h2);
    applyStimulus(1'b1, 6'h10, 5'd4, 32'h99);
    tick();
    checkOutput("movei_wb_data", wb_data, 32'h99);
    checkOutput("movei_count", 32'(wb_count), 32'h3);

    // STORE: no write, stays ready
    applyStimulus(1'b1, 6'h03, 5'd5, 32'h77);
    tick();
    checkOutput("store_wb_en", 32'(wb_en), 32'h0);
    checkOutput("store_in_ready", 32'(in_ready), 32'h1);
    checkOutput("store_count", 32'(wb_count), 32'h3);

    // LOAD rd=3; coincident mem_rvalid at acceptance is ignored, and an
    // ADD held on in_valid during the wait must not be accepted.
    applyStimulus(1'b1, 6'h04, 5'd3, 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD;
    tick();
    mem_rvalid = 1'b0;
    applyStimulus(1'b1, 6'h01, 5'd9, 32'hBAD);
    for (int i = 0; i < 3; i++) begin
      checkOutput("load_stall", 32'(stall), 32'h1);
      checkOutput("load_no_wb", 32'(wb_en), 32'h0);
      tick();
    end
    checkOutput("load_stall4", 32'(stall), 32'h1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234;
    tick();
    applyStimulus(1'b0, 6'h00, 5'd0, 32'h0);
    mem_rvalid = 1'b0;
    checkOutput("load_wb_en", 32'(wb_en), 32'h1);
    checkOutput("load_wb_addr", 32'(wb_addr), 32'h3);
    checkOutput("load_wb_data", wb_data, 32'h1234);
    checkOutput("load_in_ready", 32'(in_ready), 32'h1);
    checkOutput("load_count", 32'(wb_count), 32'h4);

    // LOAD timeout, no data ever
    applyStimulus(1'b1, 6'h04, 5'd6, 32'h0);
    tick();
    applyStimulus(1'b0, 6'h00, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("tmo_no_err_yet", 32'(mem_err), 32'h0);
    end
    tick();
    checkOutput("tmo_mem_err", 32'(mem_err), 32'h1);
    checkOutput("tmo_no_wb", 32'(wb_en), 32'h0);
    checkOutput("tmo_in_ready", 32'(in_ready), 32'h1);
    checkOutput("tmo_count", 32'(wb_count), 32'h4);
    tick();
    checkOutput("tmo_err_pulse_end", 32'(mem_err), 32'h0);

    // LOAD with data arriving exactly on the timeout edge
    applyStimulus(1'b1, 6'h04, 5'd8, 32'h0);
    tick();
    applyStimulus(1'b0, 6'h00, 5'd0, 32'h0);
    tick();
    tick();
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBEEF;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("tmo_edge_wb_en", 32'(wb_en), 32'h1);
    checkOutput("tmo_edge_mem_err", 32'(mem_err), 32'h0);
    checkOutput("tmo_edge_data", wb_data, 32'hBEEF);
    checkOutput("tmo_edge_count", 32'(wb_count), 32'h5);

    // MOVEI to r0 is dropped
    applyStimulus(1'b1, 6'h10, 5'd0, 32'h5);
    tick();
    checkOutput("r0_wb_en", 32'(wb_en), 32'h0);
    checkOutput("r0_count", 32'(wb_count), 32'h5);
    checkOutput("r0_fwd_addr", 32'(fwd_addr), 32'h8);

    // Illegal opcode 3F
    applyStimulus(1'b1, 6'h3F, 5'd2, 32'h0);
    tick();
    applyStimulus(1'b0, 6'h00, 5'd0, 32'h0);
    checkOutput("ill_pulse", 32'(illegal_op), 32'h1);
    checkOutput("ill_wb_en", 32'(wb_en), 32'h0);
    checkOutput("ill_wb_data", wb_data, 32'hFFFF_FFFF);
    checkOutput("ill_wb_addr_hold", 32'(wb_addr), 32'h8);
    tick();
    checkOutput("ill_pulse_end", 32'(illegal_op), 32'h0);
    checkOutput("ill_count", 32'(wb_count), 32'h5);

    // Reset two cycles into a load wait, with data arriving at the same edge
    applyStimulus(1'b1, 6'h04, 5'd1, 32'h0);
    tick();
    applyStimulus(1'b0, 6'h00, 5'd0, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE;
    tick();
    checkOutput("rstw_wb_en", 32'(wb_en), 32'h0);
    checkOutput("rstw_wb_addr", 32'(wb_addr), 32'h0);
    checkOutput("rstw_wb_data", wb_data, 32'h0);
    checkOutput("rstw_fwd_valid", 32'(fwd_valid), 32'h0);
    checkOutput("rstw_fwd_data", fwd_data, 32'h0);
    checkOutput("rstw_mem_err", 32'(mem_err), 32'h0);
    checkOutput("rstw_count", 32'(wb_count), 32'h0);
    rst = 1'b0;
    mem_rvalid = 1'b0;
    tick();
    checkOutput("rstw_in_ready", 32'(in_ready), 32'h1);
    checkOutput("rstw_no_wb", 32'(wb_en), 32'h0);

    // 65536 back-to-back ADDs wrap the counter
    applyStimulus(1'b1, 6'h01, 5'd1, 32'h0);
    for (int i = 0; i < 65535; i++) begin
      alu_val = 32'(i);
      tick();
    end
    checkOutput("wrap_ffff", 32'(wb_count), 32'hFFFF);
    tick();
    applyStimulus(1'b0, 6'h00, 5'd0, 32'h0);
    checkOutput("wrap_zero", 32'(wb_count), 32'h0);
    checkOutput("wrap_wb_en", 32'(wb_en), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_commit_stage.md
WB_COMMIT_STAGE -- requirements
Module: wb_commit_stage

Interface
REQ-001 The block SHALL take parameter DW, default 32, as the width of every data value.
REQ-002 The block SHALL take parameter AW, default 5, as the register-address width.
REQ-003 The block SHALL take parameter TMO, default 16 (range 2..255), as the maximum number of load-wait cycles.
REQ-004 The block SHALL take parameter R0_ZERO, default 1; when it is 1, writes to rd=0 are suppressed.
REQ-005 The block SHALL have exactly one clock and a synchronous, active-high reset: `clk  in  1  clock`, then `rst  in  1  synchronous active-high reset`.
REQ-006 The block SHALL have the following inputs:
- `in_valid  in  1  stage-3 instruction present`
- `opcode  in  6  stage-3 opcode`
- `rd  in  AW  destination register`
- `rs1_val  in  DW  source operand for MOVE`
- `alu_val  in  DW  ALU result`
- `imm_val  in  DW  immediate for MOVEI`
- `mem_rdata  in  DW  load data`
- `mem_rvalid  in  1  load data valid`
REQ-007 The block SHALL have the following outputs:
- `in_ready  out  1  stage can accept`
- `stall  out  1  equals NOT in_ready`
- `wb_en  out  1  register-file write strobe`
- `wb_addr  out  AW  write address`
- `wb_data  out  DW  write data`
- `fwd_valid  out  1  forward register holds a committed write`
- `fwd_addr  out  AW  last committed address`
- `fwd_data  out  DW  last committed data`
- `illegal_op  out  1  one-cycle pulse`
- `mem_err  out  1  one-cycle pulse on load timeout`
- `wb_count  out  16  committed-write counter`

Function
REQ-008 The block SHALL decode opcodes in these classes:
- ALU class: 01,02,06-0F,11,12,13,14.
- STORE: 03.
- LOAD: 04.
- MOVE: 05.
- MOVEI: 10.
- NOP: 00.
- Illegal: all other codes.
REQ-009 An instruction SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; otherwise the inputs are ignored.
REQ-010 The block SHALL implement the FSM states IDLE and WAIT_MEM; in_ready SHALL be 1 only in IDLE.
REQ-011 For an accepted ALU, MOVE or MOVEI instruction, wb_en SHALL be 1 for exactly the one cycle following the accepting edge, with wb_data = alu_val, rs1_val or imm_val respectively, and wb_addr = rd; the latency is 1 cycle.
REQ-012 For an accepted NOP or STORE, wb_en SHALL stay 0 and the FSM SHALL stay in IDLE.
REQ-013 For an accepted illegal opcode, wb_en SHALL stay 0, illegal_op SHALL pulse for 1 cycle, and wb_data SHALL be driven to all-ones.
REQ-014 An accepted LOAD SHALL latch rd, move the FSM to WAIT_MEM, and clear the wait counter to 0.
REQ-015 In WAIT_MEM, an edge with mem_rvalid=1 SHALL produce a 1-cycle write of mem_rdata to the latched rd and return the FSM to IDLE, so that in_ready=1 in the same cycle as wb_en.
REQ-016 In WAIT_MEM, each edge with mem_rvalid=0 SHALL increment the wait counter; the edge at which the counter equals TMO-1 SHALL return the FSM to IDLE with no write and a 1-cycle mem_err pulse.
REQ-017 When mem_rvalid=1 on the timeout edge, the data SHALL be written and mem_err SHALL stay 0.
REQ-018 mem_rvalid SHALL be ignored while in IDLE, including when it coincides with LOAD acceptance.
REQ-019 When R0_ZERO=1 and the target is rd=0, the write SHALL be suppressed: wb_en=0, and fwd and wb_count are unchanged; the FSM transitions are unaffected.
REQ-020 Every asserted wb_en SHALL load {fwd_addr, fwd_data} with {wb_addr, wb_data} on the same edge and set fwd_valid=1; the forward register SHALL hold its value otherwise.
REQ-021 wb_count SHALL increment by 1 per asserted wb_en and wrap from FFFF to 0000.
REQ-022 When wb_en=0, wb_addr and wb_data SHALL hold their previous values, except in the illegal-opcode case of REQ-013.
REQ-023 All outputs SHALL be registered except in_ready and stall, which are decoded from the FSM state.

Reset
REQ-024 While rst=1 at a clock edge, the block SHALL force: FSM=IDLE, wait counter=0, wb_en=0, wb_addr=0, wb_data=0, fwd_valid=0, fwd_addr=0, fwd_data=0, illegal_op=0, mem_err=0, wb_count=0.
REQ-025 Reset SHALL take priority over every other event, including in_valid and mem_rvalid.
REQ-026 A reset during WAIT_MEM SHALL abandon the pending load with no write and no mem_err.
REQ-027 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-028 The bench SHALL cover: ADD (01), rd=7, alu_val=0x0000_00AA -> next cycle wb_en=1, wb_addr=7, wb_data=0xAA, fwd=(7,0xAA), wb_count=1.
REQ-029 The bench SHALL cover: LOAD rd=3, then mem_rvalid=1 with mem_rdata=0x1234 on the 4th edge after acceptance -> stall=1 for 4 cycles, then wb_en=1, wb_data=0x1234, in_ready=1.
REQ-030 The bench SHALL cover: LOAD with TMO=4 and mem_rvalid never asserted -> mem_err pulse once, 4 cycles after acceptance, with no wb_en; a repeat run with mem_rvalid on that edge -> write occurs and mem_err=0.
REQ-031 The bench SHALL cover: MOVEI (10) rd=0, imm_val=5, with R0_ZERO=1 -> wb_en=0 and wb_count unchanged; opcode 0x3F -> illegal_op pulse and no write.
REQ-032 The bench SHALL cover: rst asserted 2 cycles into a LOAD wait -> no write, in_ready=1 after release, and all outputs at their reset values.
REQ-033 The bench SHALL cover: 65536 back-to-back ADD writes -> wb_count wraps to 0000.
